// File: rtl/sync_lifo.sv
// sync_lifo: single-clock LIFO stack on a pointer-addressed register array.
// Zero-latency peek, status outputs, push+pull replace, sticky error flags.
module sync_lifo #(
   parameter  int WIDTH     = 8,
   parameter  int DEPTH     = 8,
   parameter  int AFULL_LVL = DEPTH - 1,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             psh,
   input  logic             pll,
   input  logic             err_clr,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic [CW-1:0]    count,
   output logic             ovf,
   output logic             udf
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]    sp_q, sp_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [AW-1:0]    top_idx;
   logic             is_full, is_empty;
   logic             ovf_ev, udf_ev;

   assign is_full  = (sp_q == CW'(DEPTH));
   assign is_empty = (sp_q == '0);

   // Guarded so an empty stack never forms an out-of-range index.
   assign top_idx  = is_empty ? '0 : AW'(sp_q - CW'(1));

   // Decode the requested operation against the current fill state.
   always_comb begin
      sp_d   = sp_q;
      we     = 1'b0;
      waddr  = top_idx;
      ovf_ev = 1'b0;
      udf_ev = 1'b0;
      unique case ({psh, pll})
         2'b10: begin
            if (is_full) begin
               ovf_ev = 1'b1;
            end else begin
               we    = 1'b1;
               waddr = AW'(sp_q);
               sp_d  = sp_q + CW'(1);
            end
         end
         2'b01: begin
            if (is_empty) udf_ev = 1'b1;
            else          sp_d   = sp_q - CW'(1);
         end
         2'b11: begin
            if (is_empty) begin
               we     = 1'b1;
               waddr  = '0;
               sp_d   = CW'(1);
               udf_ev = 1'b1;
            end else begin
               we    = 1'b1;
               waddr = top_idx;
            end
         end
         default: ;
      endcase
      // An error on the same edge as err_clr keeps the flag set.
      ovf_d = ovf_ev | (ovf_q & ~err_clr);
      udf_d = udf_ev | (udf_q & ~err_clr);
   end

   // Stack pointer and sticky flags; reset discards any pending operation.
   always_ff @(posedge clkin) begin
      if (rst) begin
         sp_q  <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   // Storage array; contents are never reset, popped words are left in place.
   always_ff @(posedge clkin) begin
      if (we && !rst) mem_q[waddr] <= in;
   end

   assign out         = is_empty ? '0 : mem_q[top_idx];
   assign full        = is_full;
   assign empty       = is_empty;
   assign almost_full = (sp_q >= CW'(AFULL_LVL));
   assign count       = sp_q;
   assign ovf         = ovf_q;
   assign udf         = udf_q;

endmodule

// File: tb/tb_sync_lifo.sv
// tb_sync_lifo: directed scenarios on an 8x8 stack plus a randomised
// run of a 5x13 stack against a queue reference model.
module tb_sync_lifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: WIDTH=8, DEPTH=8, AFULL_LVL=7
   logic       a_rst, a_psh, a_pll, a_clr;
   logic [7:0] a_in, a_out;
   logic       a_full, a_empty, a_afull, a_ovf, a_udf;
   logic [3:0] a_count;

   // DUT B: WIDTH=13, DEPTH=5, AFULL_LVL=3
   logic        b_rst, b_psh, b_pll, b_clr;
   logic [12:0] b_in, b_out;
   logic        b_full, b_empty, b_afull, b_ovf, b_udf;
   logic [2:0]  b_count;

   sync_lifo #(.WIDTH(8), .DEPTH(8), .AFULL_LVL(7)) u_a (
      .clkin(clk), .rst(a_rst), .psh(a_psh), .pll(a_pll),
      .err_clr(a_clr), .in(a_in), .out(a_out), .full(a_full),
      .empty(a_empty), .almost_full(a_afull), .count(a_count),
      .ovf(a_ovf), .udf(a_udf)
   );

   sync_lifo #(.WIDTH(13), .DEPTH(5), .AFULL_LVL(3)) u_b (
      .clkin(clk), .rst(b_rst), .psh(b_psh), .pll(b_pll),
      .err_clr(b_clr), .in(b_in), .out(b_out), .full(b_full),
      .empty(b_empty), .almost_full(b_afull), .count(b_count),
      .ovf(b_ovf), .udf(b_udf)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // {count, full, empty, almost_full, ovf, udf, out}
   logic [16:0] a_vec;
   logic [20:0] b_vec;
   assign a_vec = {a_count, a_full, a_empty, a_afull, a_ovf, a_udf, a_out};
   assign b_vec = {b_count, b_full, b_empty, b_afull, b_ovf, b_udf, b_out};

   function automatic logic [16:0] mk_a(int c, bit o, bit u, logic [7:0] d);
      return {4'(c), c == 8, c == 0, c >= 7, o, u, d};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_idle();
      a_rst = 0; a_psh = 0; a_pll = 0; a_clr = 0; a_in = '0;
   endtask

   task automatic test_reset();
      a_rst = 1; b_rst = 1;
      step();
      a_idle();
      b_rst = 0;
      n_cmp++;
      if (a_vec !== mk_a(0, 0, 0, 8'h00)) begin
         n_bad++;
         $display("FAIL reset: got %h want %h", a_vec, mk_a(0, 0, 0, 8'h00));
      end
   endtask

   task automatic test_fill();
      logic [16:0] e;
      for (int i = 1; i <= 8; i++) begin
         a_psh = 1; a_in = 8'(i * 8'h11);
         step();
         e = mk_a(i, 0, 0, 8'(i * 8'h11));
         n_cmp++;
         if (a_vec !== e) begin
            n_bad++;
            $display("FAIL fill[%0d]: got %h want %h", i, a_vec, e);
         end
      end
      a_in = 8'h99;
      step();
      a_idle();
      e = mk_a(8, 1, 0, 8'h88);
      n_cmp++;
      if (a_vec !== e) begin
         n_bad++;
         $display("FAIL overflow: got %h want %h", a_vec, e);
      end
   endtask

   task automatic test_drain();
      logic [16:0] e;
      for (int i = 1; i <= 8; i++) begin
         a_pll = 1;
         step();
         e = mk_a(8 - i, 1, 0, 8'((8 - i) * 8'h11));
         n_cmp++;
         if (a_vec !== e) begin
            n_bad++;
            $display("FAIL drain[%0d]: got %h want %h", i, a_vec, e);
         end
      end
      step();
      a_idle();
      e = mk_a(0, 1, 1, 8'h00);
      n_cmp++;
      if (a_vec !== e) begin
         n_bad++;
         $display("FAIL underflow: got %h want %h", a_vec, e);
      end
      a_clr = 1;
      step();
      a_idle();
      e = mk_a(0, 0, 0, 8'h00);
      n_cmp++;
      if (a_vec !== e) begin
         n_bad++;
         $display("FAIL err_clr: got %h want %h", a_vec, e);
      end
   endtask

   task automatic test_replace();
      logic [16:0] e;
      a_psh = 1; a_in = 8'hA1; step();
      a_in = 8'hA2; step();
      a_pll = 1; a_in = 8'hB3; step();
      a_idle();
      e = mk_a(2, 0, 0, 8'hB3);
      n_cmp++;
      if (a_vec !== e) begin
         n_bad++;
         $display("FAIL replace: got %h want %h", a_vec, e);
      end
      a_pll = 1; step();
      e = mk_a(1, 0, 0, 8'hA1);
      n_cmp++;
      if (a_vec !== e) begin
         n_bad++;
         $display("FAIL replace_pop: got %h want %h", a_vec, e);
      end
      step();
      a_idle();
      e = mk_a(0, 0, 0, 8'h00);
      n_cmp++;
      if (a_vec !== e) begin
         n_bad++;
         $display("FAIL replace_empty: got %h want %h", a_vec, e);
      end
   endtask

   task automatic test_empty_replace();
      logic [16:0] e;
      a_psh = 1; a_pll = 1; a_in = 8'h5C;
      step();
      a_idle();
      e = mk_a(1, 0, 1, 8'h5C);
      n_cmp++;
      if (a_vec !== e) begin
         n_bad++;
         $display("FAIL empty_repl: got %h want %h", a_vec, e);
      end
      a_pll = 1; step();
      a_clr = 1; step();
      a_idle();
      e = mk_a(0, 0, 1, 8'h00);
      n_cmp++;
      if (a_vec !== e) begin
         n_bad++;
         $display("FAIL set_wins: got %h want %h", a_vec, e);
      end
      a_clr = 1; step();
      a_idle();
      e = mk_a(0, 0, 0, 8'h00);
      n_cmp++;
      if (a_vec !== e) begin
         n_bad++;
         $display("FAIL clr_udf: got %h want %h", a_vec, e);
      end
   endtask

   task automatic test_rst_push();
      logic [16:0] e;
      a_pll = 1; step();
      a_idle();
      for (int i = 1; i <= 5; i++) begin
         a_psh = 1; a_in = 8'(8'h20 + i); step();
      end
      a_idle();
      e = mk_a(5, 0, 1, 8'h25);
      n_cmp++;
      if (a_vec !== e) begin
         n_bad++;
         $display("FAIL pre_rst: got %h want %h", a_vec, e);
      end
      a_rst = 1; a_psh = 1; a_in = 8'hFF;
      step();
      a_idle();
      e = mk_a(0, 0, 0, 8'h00);
      n_cmp++;
      if (a_vec !== e) begin
         n_bad++;
         $display("FAIL rst_psh: got %h want %h", a_vec, e);
      end
      a_psh = 1; a_in = 8'h3E; step();
      a_idle();
      e = mk_a(1, 0, 0, 8'h3E);
      n_cmp++;
      if (a_vec !== e) begin
         n_bad++;
         $display("FAIL post_rst: got %h want %h", a_vec, e);
      end
   endtask

   task automatic test_random();
      logic [12:0] q[$];
      bit          m_ovf, m_udf, eo, eu;
      logic [20:0] e;
      int          sz;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         b_rst = ($urandom_range(0, 255) == 0);
         b_psh = $urandom_range(0, 1) == 1;
         b_pll = $urandom_range(0, 1) == 1;
         b_clr = ($urandom_range(0, 7) == 0);
         b_in  = 13'($urandom);
         step();
         eo = 0; eu = 0;
         if (b_rst) begin
            q.delete();
            m_ovf = 0; m_udf = 0;
         end else begin
            if (b_psh && b_pll) begin
               if (q.size() == 0) begin
                  q.push_back(b_in); eu = 1;
               end else begin
                  q[q.size() - 1] = b_in;
               end
            end else if (b_psh) begin
               if (q.size() == 5) eo = 1;
               else q.push_back(b_in);
            end else if (b_pll) begin
               if (q.size() == 0) eu = 1;
               else void'(q.pop_back());
            end
            m_ovf = eo ? 1'b1 : (b_clr ? 1'b0 : m_ovf);
            m_udf = eu ? 1'b1 : (b_clr ? 1'b0 : m_udf);
         end
         sz = q.size();
         e = {3'(sz), sz == 5, sz == 0, sz >= 3, m_ovf, m_udf,
              (sz == 0) ? 13'h0 : q[sz - 1]};
         n_cmp++;
         if (b_vec !== e) begin
            n_bad++;
            $display("FAIL random[%0d]: got %h want %h", cyc, b_vec, e);
         end
      end
      b_rst = 0; b_psh = 0; b_pll = 0; b_clr = 0;
   endtask

   initial begin
      a_idle();
      b_rst = 0; b_psh = 0; b_pll = 0; b_clr = 0; b_in = '0;
      test_reset();
      test_fill();
      test_drain();
      test_replace();
      test_empty_replace();
      test_rst_push();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sync_lifo.md
# sync_lifo

Synchronous, parametrised LIFO (stack) storage block: single clock, pointer-addressed register array instead of a shifting latch chain. Provides zero-latency peek of the top entry, full/empty/almost-full status, an occupancy count, a defined push+pull "replace" operation and sticky overflow/underflow error flags. It is a drop-in stack for datapath and control blocks that need bounded last-in-first-out buffering with error visibility.

## Interface
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 8, number of entries (>=2)
- AFULL_LVL, DEPTH-1, count at or above which almost_full asserts (1..DEPTH)
- CW, $clog2(DEPTH+1), count width (derived, not overridden)

- clkin  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- psh  in  1  push request
- pll  in  1  pull (pop) request
- err_clr  in  1  clears sticky ovf/udf
- in  in  WIDTH  push data
- out  out  WIDTH  current top entry (peek); 0 when empty
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_LVL
- count  out  CW  number of valid entries
- ovf  out  1  sticky: push rejected while full
- udf  out  1  sticky: pull rejected while empty

## Operation
- Storage: DEPTH x WIDTH register array mem[0..DEPTH-1]; stack pointer sp (CW bits) = count; top entry is mem[sp-1].
- All outputs derived combinationally from sp, mem and sticky flags; no output depends combinationally on psh/pll/in.
- Per-edge action (rst low), from {psh, pll, full, empty}:
  - 00: hold.
  - psh only, not full: mem[sp] <= in; sp <= sp+1.
  - psh only, full: no write, sp held, ovf <= 1.
  - pll only, not empty: sp <= sp-1. Popped word is not cleared (don't-care storage).
  - pll only, empty: sp held, udf <= 1.
  - psh+pll, not empty (including full): replace — mem[sp-1] <= in; sp unchanged; no error.
  - psh+pll, empty: push only (mem[0] <= in, sp <= 1); udf <= 1.
- err_clr: ovf, udf <= 0 on that edge; if an error condition occurs on the same edge, the set wins.
- Sticky flags only change via error event, err_clr or rst.
- sp never exceeds DEPTH and never wraps below 0.

## Timing
- Reset: on rising edge with rst=1: sp=0, ovf=0, udf=0; hence out=0, empty=1, full=0, almost_full=0 (unless AFULL_LVL==0, disallowed), count=0. Memory contents not reset. rst overrides psh/pll/err_clr on that edge; a push or pull in progress is discarded.
- Peek latency 0: out reflects the top entry in the same cycle sp/mem update settles, i.e. a word pushed at edge N is on out after edge N.
- Push-to-pull turnaround: pull at edge N+1 returns (removes) the word pushed at edge N; after that edge out shows the previous top.
- Status (full/empty/almost_full/count) update in the cycle after the causing edge; no look-ahead.
- Throughput: one operation per cycle, sustained indefinitely; no stall or ready signal.
- Error flags assert the cycle after the offending edge and stay high until err_clr or rst.

## Test plan
- Reset then 8 pushes of 0x11..0x88 (WIDTH=8, DEPTH=8) -> count 1..8, almost_full at count 7, full at 8, out=0x88; 9th push 0x99 -> count stays 8, out=0x88, ovf=1.
- From full, 8 pulls -> out sequence 0x77,0x66,...,0x11,0x00, empty=1 after 8th; 9th pull -> udf=1, count=0; err_clr -> ovf=udf=0.
- Push 0xA1, 0xA2 then psh+pll with in=0xB3 -> count stays 2, out=0xB3; pull -> out=0xA1.
- Empty stack, psh+pll with in=0x5C -> count=1, out=0x5C, udf=1; same cycle err_clr on a later udf event -> udf remains 1.
- Fill to count 5, assert rst together with psh=1 -> next cycle count=0, empty=1, out=0, ovf=udf=0; subsequent push 0x3E -> out=0x3E, count=1.
- Randomised psh/pll/err_clr for 10k cycles against a queue model (DEPTH=5, WIDTH=13, AFULL_LVL=3) -> out, count, flags match every cycle.
